seg7_scan_ctrl: RTL

Scan controller for the 4-digit multiplexed 7-segment display on the UART board. Accepts received UART bytes through a valid/ready handshake and packs each pair of bytes into a 4-hex-digit word. Commits the word tear-free at frame boundaries, then time-multiplexes anodes and segment patterns with an anti-ghosting guard interval.

---
 rtl/seg7_scan_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// 4-digit multiplexed 7-segment scan controller with byte-pair intake and frame-synchronous commit.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seg7_scan_ctrl #(
  parameter int unsigned DWELL_CYCLES = 100000,
  parameter int unsigned GUARD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic       clr,
  input  logic [3:0] dp_in,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int unsigned CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  typedef enum logic {
    S_HOLD,
    S_RUN
  } run_t;

  run_t          state, state_nxt;
  logic [CW-1:0] dwell_cnt;
  logic [1:0]    idx;
  logic [15:0]   disp;
  logic [15:0]   stage;
  logic          byte_cnt;
  logic          pending;

  logic          accept;
  logic          dwell_wrap;
  logic          frame_bnd;
  logic [3:0]    nib;
  logic          blank_lz;
  logic [6:0]    seg_nxt;
  logic [3:0]    an_nxt;
  logic          dp_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // S_HOLD lasts exactly one cycle after reset release; it keeps rx_ready low and the scan parked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_HOLD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == S_HOLD) state_nxt = S_RUN;
  end

  assign rx_ready   = (state == S_RUN) && !pending && !clr;
  assign accept     = rx_valid && rx_ready;
  assign dwell_wrap = (state == S_RUN) && (dwell_cnt == CW'(DWELL_CYCLES - 1));
  assign frame_bnd  = dwell_wrap && (idx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_cnt  <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_bnd;
      if (state == S_RUN) begin
        if (dwell_wrap) begin
          dwell_cnt <= '0;
          idx       <= idx + 2'd1;
        end else begin
          dwell_cnt <= dwell_cnt + 1'b1;
        end
      end
    end
  end

  // Accept and commit are mutually exclusive: a pending pair already holds rx_ready low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp     <= '0;
      stage    <= '0;
      byte_cnt <= 1'b0;
      pending  <= 1'b0;
    end else if (clr) begin
      disp     <= '0;
      stage    <= '0;
      byte_cnt <= 1'b0;
      pending  <= 1'b0;
    end else begin
      if (accept) begin
        stage    <= {stage[7:0], rx_data};
        byte_cnt <= ~byte_cnt;
        if (byte_cnt) pending <= 1'b1;
      end
      if (frame_bnd && pending) begin
        disp    <= stage;
        pending <= 1'b0;
      end
    end
  end

  always_comb begin
    nib = '0;
    case (idx)
      2'd0: nib = disp[3:0];
      2'd1: nib = disp[7:4];
      2'd2: nib = disp[11:8];
      default: nib = disp[15:12];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    blank_lz = 1'b0;
    case (idx)
      2'd1: blank_lz = (disp[15:4] == '0);
      2'd2: blank_lz = (disp[15:8] == '0);
      2'd3: blank_lz = (disp[15:12] == '0);
      default: blank_lz = 1'b0;
    endcase
  end
`else
  assign blank_lz = 1'b0;
`endif

  always_comb begin
    an_nxt  = '1;
    seg_nxt = '1;
    dp_nxt  = 1'b1;
    if (dwell_cnt >= CW'(GUARD_CYCLES)) begin
      an_nxt  = ~(4'b0001 << idx);
      seg_nxt = blank_lz ? 7'h7F : hex7(nib);
      dp_nxt  = ~dp_in[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= '1;
      seg <= '1;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule
